ahb_lite_cmd_master: RTL
========================

Name: ahb_lite_cmd_master

Overview:
- Command-driven AHB-Lite bus master that sits directly upstream of the on-chip RAM and peripheral slaves, through the address decoder/mux.
- Converts a simple valid/ready request stream (from a UART bridge or DMA engine) into pipelined single AHB-Lite transfers.
- Returns one response per command: read data plus error flag.
- Supports back-to-back transfers, HREADY wait states and two-cycle HRESP error cancellation.

Parameters:
- ADDR_W, 32, width of HADDR and cmd_addr.
- DATA_W, 32, width of HWDATA/HRDATA/cmd_wdata/rsp_rdata; fixed at 32 in this design.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_size  in  2  HSIZE[1:0]: 00 byte, 01 halfword, 10 word.
- cmd_wdata  in  DATA_W  write data, already lane-replicated by the client.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_write  out  1  echo of the command's cmd_write.
- rsp_err  out  1  transfer got ERROR or was cancelled.
- rsp_rdata  out  DATA_W  HRDATA for reads; 0 for writes and errors.
- HADDR  out  ADDR_W  address-phase address.
- HTRANS  out  2  IDLE 00 / NONSEQ 10 only.
- HWRITE  out  1  address-phase direction.
- HSIZE  out  3  {1'b0, size}.
- HBURST  out  3  constant 000 (SINGLE).
- HPROT  out  4  constant 0011.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  DATA_W  data-phase write data.
- HREADY  in  1  from slave mux; transfer completes when high.
- HRDATA  in  DATA_W  read data.
- HRESP  in  1  0 OKAY, 1 ERROR.

Behaviour:
- **Structure.** Two registered stages:
  - AP (address phase): ap_valid, addr, write, size, wdata, cancel.
  - DP (data phase): dp_valid, write, HWDATA.
  - All bus outputs come straight from registers; no combinational path from cmd_* to H* signals.
- **Reset (HRESET=1 at an edge).** ap_valid=0, dp_valid=0, cancel=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_err=0, rsp_write=0, rsp_rdata=0.
  - Reset mid-transfer drops all outstanding commands with no response.
- **Output decode.**
  - HTRANS = NONSEQ when ap_valid & ~cancel, else IDLE.
  - HADDR/HWRITE/HSIZE reflect the AP register and hold stable while HREADY=0.
- **Command acceptance.**
  - cmd_ready = ~cancel & (~ap_valid | HREADY). Combinational from HREADY and state.
  - An accepted command loads AP at the edge and appears on HTRANS the next cycle. Latency: cmd accept edge +1 cycle = address phase.
- **Advance (edge with HREADY=1, cancel=0).**
  - DP <= AP: dp_valid=ap_valid, HWDATA<=ap.wdata.
  - AP <= new command if accepted, else ap_valid=0.
- **Completion (edge with HREADY=1 and dp_valid).** The next cycle has:
  - rsp_valid=1, rsp_write=dp.write, rsp_err=HRESP.
  - rsp_rdata=HRDATA if read & OKAY, else 0.
- **Wait states.** Edge with HREADY=0: AP and DP hold. No response.
- **Error handling.** Edge with dp_valid & HREADY=0 & HRESP=1 (first ERROR cycle):
  - Set cancel=1. HTRANS goes IDLE the following cycle (AHB-Lite two-cycle cancel).
  - At the second ERROR cycle edge (HREADY=1, HRESP=1): DP completes with rsp_err=1.
  - If ap_valid, the AP command is discarded, not issued. It produces a second response (rsp_err=1, rsp_write echoed, rdata=0) in the cycle after the first response.
  - DP is cleared, ap_valid=0, cancel=0.
  - cmd_ready=0 throughout cancel.
- **Responses.**
  - Responses are in command order, one per command, never coalesced.
  - rsp_valid is low in any cycle without a completion.
- **Idle bus.** HTRANS=IDLE with HREADY=1 produces no response.

Test Plan:
- **Single write then read.** Reset; write 0xDEADBEEF, word, addr 0x20; then read 0x20 with an OKAY slave → HTRANS NONSEQ one cycle after each accept. Write response rsp_err=0, rdata=0; read response rdata=0xDEADBEEF.
- **Back-to-back, zero wait.** 4 word writes to 0x0,0x4,0x8,0xC with cmd_valid held → cmd_ready stays 1. HTRANS NONSEQ for 4 consecutive cycles, HWDATA lags HADDR by exactly 1 cycle, 4 rsp pulses in consecutive cycles.
- **Wait states.** Slave holds HREADY=0 for 3 cycles on a read of 0x100 with a write to 0x104 queued → HADDR=0x104 and HTRANS stable for all 3 cycles, cmd_ready=0, read response arrives 1 cycle after HREADY rises.
- **Error cancel.** Slave returns ERROR on a read of 0x4000 while a write to 0x4004 sits in AP → HTRANS=IDLE in the 2nd error cycle. Two responses: (read, err=1) then (write, err=1). 0x4004 is never issued.
- **Byte/halfword sizing.** Byte write 0xAA replicated as 0xAAAAAAAA to 0x3 → HSIZE=000, HADDR=0x3. Halfword read of 0x2 → HSIZE=001, rdata = full HRDATA word.
- **Reset mid-operation.** Assert HRESET during a wait state with AP and DP valid → next cycle HTRANS=IDLE, rsp_valid=0, no stale response after reset is released.

Source files
------------

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-transfer bus master driven by a valid/ready command stream.
// Address-phase (p0) and data-phase (p1) registers feed the bus; responses are registered (p2).
module ahb_lite_cmd_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic              vld_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              write_p0;
    logic [1:0]        size_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              cancel;

    logic              vld_p1;
    logic              write_p1;
    logic [DATA_W-1:0] wdata_p1;

    // Discarded address-phase command still owed an error response after a cancel.
    logic              pend_vld;
    logic              pend_write;

    logic              accept;

    assign cmd_ready = ~cancel & (~vld_p0 | HREADY);
    assign accept    = cmd_valid & cmd_ready;

    assign HTRANS    = (vld_p0 & ~cancel) ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR     = addr_p0;
    assign HWRITE    = write_p0;
    assign HSIZE     = {1'b0, size_p0};
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = wdata_p1;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            vld_p0     <= 1'b0;
            addr_p0    <= '0;
            write_p0   <= 1'b0;
            size_p0    <= 2'b00;
            cancel     <= 1'b0;
            vld_p1     <= 1'b0;
            write_p1   <= 1'b0;
            wdata_p1   <= '0;
            pend_vld   <= 1'b0;
            pend_write <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            pend_vld  <= 1'b0;

            // p2: owed second error response goes out the cycle after the first
            if (pend_vld) begin
                rsp_valid <= 1'b1;
                rsp_write <= pend_write;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end

            if (cancel) begin
                if (HREADY) begin
                    rsp_valid  <= vld_p1;
                    rsp_write  <= write_p1;
                    rsp_err    <= 1'b1;
                    rsp_rdata  <= '0;
                    pend_vld   <= vld_p0;
                    pend_write <= write_p0;
                    vld_p0     <= 1'b0;
                    vld_p1     <= 1'b0;
                    cancel     <= 1'b0;
                end
            end else begin
                // p1 -> p2: data phase completes on HREADY
                if (HREADY) begin
                    if (vld_p1) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= write_p1;
                        rsp_err   <= HRESP;
                        rsp_rdata <= (~write_p1 & ~HRESP) ? HRDATA : '0;
                    end
                    // p0 -> p1
                    vld_p1   <= vld_p0;
                    write_p1 <= write_p0;
                    wdata_p1 <= wdata_p0;
                end else if (vld_p1 & HRESP) begin
                    cancel <= 1'b1;
                end

                // cmd -> p0
                if (accept) begin
                    vld_p0   <= 1'b1;
                    addr_p0  <= cmd_addr;
                    write_p0 <= cmd_write;
                    size_p0  <= cmd_size;
                    wdata_p0 <= cmd_wdata;
                end else if (HREADY) begin
                    vld_p0 <= 1'b0;
                end
            end
        end
    end

endmodule
